dsp_mac_array: RTL and testbench
================================

// Module: dsp_mac_array
// PURPOSE
//  Responder side of the NPU DSP lane interface: N_LANES parallel pipelined multiply-accumulate lanes.
//  Each lane takes the operand pairs (dsp_a0, dsp_b0) that the convolution/matmul sequencers drive.
//  Each lane sums TAPS consecutive products (one window, e.g. 9 taps for 3x3) and returns the sum on dsp_out.
//  Sits between the sequencers and the fabric DSP slices; it is the single owner of multiply timing.
// PARAMETERS
//  N_LANES  16  number of parallel MAC lanes
//  A_W      18  operand A width
//  B_W      18  operand B width
//  P_W      37  accumulator/result width per lane
//  TAPS     9   products summed per window before result is published
//  SIGNED   0   0: unsigned operands/products; 1: two's complement
// PORTS
//  clk        in   1              clock
//  rst_n      in   1              asynchronous active-low reset
//  dsp_ce     in   1              pipeline enable; 0 freezes every stage (the pipeline stalls, nothing is dropped)
//  dsp_clr    in   1              synchronous flush: pipeline, accumulators, tap counter
//  dsp_a0     in   [N_LANES][A_W] operand A per lane
//  dsp_b0     in   [N_LANES][B_W] operand B per lane
//  dsp_out    out  [N_LANES][P_W] last completed window sum per lane (held)
//  out_valid  out  1              1-cycle pulse: dsp_out updated this cycle
//  ovf        out  [N_LANES]      sticky saturation flag per lane
//  busy       out  1              a partial window is in flight
// BEHAVIOUR
//  Reset (async): all pipe regs, accumulators, dsp_out, ovf = 0; out_valid = 0; busy = 0; tap_cnt = 0.
//  Pipeline (all stages advance only when dsp_ce=1):
//   S1: register a,b + v1<=1.  S2: prod = a*b (A_W+B_W bits), v2<=v1.  S3: acc update, v3<=v2.
//  Operands presented at ce-cycle k contribute to the accumulator after 3 ce-cycles.
//  Operands presented while ce=0 are ignored.
//  Accumulate: when S3 fires with v2=1:
//   - tap_cnt==0: acc <= prod (the first tap overwrites; no separate clear is needed).
//   - otherwise: acc <= acc + prod.
//   - tap_cnt increments; at TAPS-1 it wraps to 0, dsp_out <= new acc for all lanes, out_valid=1 for one cycle.
//  Latency: the last tap presented at ce-cycle k -> out_valid at the clock edge of ce-cycle k+3.
//  dsp_out holds until the next window completes.
//  The producer keeps dsp_ce=1 for 3 extra cycles to drain (operands are don't-care; v1 forced 1 only while producer asserts).
//  A valid qualifier is implicit: every ce=1 cycle is a tap.
//  Consequently the tap count is counted in ce cycles. Drain cycles during which dsp_ce=1 count as taps.
//  The producer must therefore present exactly TAPS ce-cycles per window, then deassert ce or start the next window.
//  Width: compute internally at P_W+1 bits.
//   - SIGNED=0: a result > 2^P_W-1 clamps to 2^P_W-1 and sets ovf[lane].
//   - SIGNED=1: clamp to [-2^(P_W-1), 2^(P_W-1)-1] and set ovf[lane].
//  ovf clears only on reset or dsp_clr.
//  dsp_clr: next edge zeroes v1..v3, acc, tap_cnt, ovf. dsp_out is NOT cleared, so the last result stays readable.
//   No out_valid is generated for a window aborted by dsp_clr.
//  dsp_clr and dsp_ce in the same cycle: clr wins; that cycle's operands are discarded.
//  dsp_ce=0 mid-window: all state is frozen, and out_valid cannot fire during the freeze.
//   A completion pending in S3 fires on the first ce=1 cycle.
//  busy = (tap_cnt!=0) | v1 | v2.
//  Reset mid-window: everything zeroes immediately, with no partial output.
// STRUCTURE
//  npu_dsp_pkg holds:
//   - localparams DSP_A_W=18, DSP_B_W=18, DSP_P_W=37, CONV_TAPS=9;
//   - typedef dsp_a_t, dsp_b_t, dsp_p_t;
//   - a function sat_add(acc, prod, signed_mode) returning {ovf, sum}.
//  One sub-module, dsp_mac_lane: S1-S3 regs, accumulator, saturation, ovf.
//   Generated N_LANES times.
//  The top level owns tap_cnt, the shared v1..v3 valid chain, out_valid and busy.
//  Lane datapath registers carry no reset beyond acc/ovf, so they map into DSP slice pipeline registers.
// TESTING
//  T1: lane i: a=i+1, b=2 for 9 ce-cycles, then 3 drain cycles ->
//      out_valid pulses once, 3 cycles after the 9th tap; dsp_out[i] = 18*(i+1).
//  T2: two back-to-back windows (a=1,b=1 then a=3,b=5, 9 taps each) ->
//      dsp_out = 9 then 135; out_valid pulses 9 cycles apart; no cross-window leakage.
//  T3: dsp_ce=0 for 4 cycles after tap 5 ->
//      result unchanged vs T1; out_valid delayed exactly 4 cycles; dsp_out stable during the stall.
//  T4: a=b=2^18-1, 9 taps, SIGNED=0 ->
//      dsp_out = 2^37-1 with ovf=1 on all lanes; dsp_clr -> ovf=0 and dsp_out retained.
//  T5: SIGNED=1, a=-3, b=7, 9 taps -> dsp_out = -189 (37-bit two's complement), ovf=0.
//  T6: dsp_clr asserted at tap 4 together with ce ->
//      no out_valid; a following 9-tap window of a=1,b=1 gives 9.
//      Async rst_n mid-window zeroes all outputs immediately.

Source files
------------

// File: rtl/npu_dsp_pkg.sv
// Shared widths, types and the saturating accumulate helper for the NPU DSP MAC lanes.
// The adder works one bit wider than the result so an overflow is visible before clamping.
package npu_dsp_pkg;

  localparam int DSP_A_W    = 18;
  localparam int DSP_B_W    = 18;
  localparam int DSP_P_W    = 37;
  localparam int CONV_TAPS  = 9;
  localparam int DSP_PROD_W = DSP_A_W + DSP_B_W;

  typedef logic [DSP_A_W-1:0]    dsp_a_t;
  typedef logic [DSP_B_W-1:0]    dsp_b_t;
  typedef logic [DSP_P_W-1:0]    dsp_p_t;
  typedef logic [DSP_PROD_W-1:0] dsp_prod_t;

  // Returns {ovf, clamped_sum}.
  function automatic logic [DSP_P_W:0] sat_add(input dsp_p_t    acc,
                                               input dsp_prod_t prod,
                                               input logic      signed_mode);
    logic [DSP_P_W:0] acc_x;
    logic [DSP_P_W:0] prod_x;
    logic [DSP_P_W:0] sum;
    dsp_p_t           res;
    logic             ovf;
    if (signed_mode) begin
      acc_x  = {acc[DSP_P_W-1], acc};
      prod_x = {{(DSP_P_W+1-DSP_PROD_W){prod[DSP_PROD_W-1]}}, prod};
    end else begin
      acc_x  = {1'b0, acc};
      prod_x = {{(DSP_P_W+1-DSP_PROD_W){1'b0}}, prod};
    end
    sum = acc_x + prod_x;
    res = sum[DSP_P_W-1:0];
    ovf = 1'b0;
    if (signed_mode) begin
      if (sum[DSP_P_W] != sum[DSP_P_W-1]) begin
        ovf = 1'b1;
        res = sum[DSP_P_W] ? {1'b1, {(DSP_P_W-1){1'b0}}} : {1'b0, {(DSP_P_W-1){1'b1}}};
      end
    end else if (sum[DSP_P_W]) begin
      ovf = 1'b1;
      res = '1;
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/dsp_mac_array_if.sv
// DSP lane bus between the convolution/matmul sequencers (master) and the MAC array (slave).
interface dsp_mac_array_if
  import npu_dsp_pkg::*;
#(
  parameter int N_LANES = 16,
  parameter int A_W     = DSP_A_W,
  parameter int B_W     = DSP_B_W,
  parameter int P_W     = DSP_P_W
);

  logic                          dsp_ce;
  logic                          dsp_clr;
  logic [N_LANES-1:0][A_W-1:0]   dsp_a0;
  logic [N_LANES-1:0][B_W-1:0]   dsp_b0;
  logic [N_LANES-1:0][P_W-1:0]   dsp_out;
  logic                          out_valid;
  logic [N_LANES-1:0]            ovf;
  logic                          busy;

  modport master (
    output dsp_ce, dsp_clr, dsp_a0, dsp_b0,
    input  dsp_out, out_valid, ovf, busy
  );

  modport slave (
    input  dsp_ce, dsp_clr, dsp_a0, dsp_b0,
    output dsp_out, out_valid, ovf, busy
  );

endinterface

// File: rtl/dsp_mac_lane.sv
// One MAC lane: operand register, product register, saturating accumulator and held result.
// Valid bits and the tap counter live in the array top and are shared by all lanes.
module dsp_mac_lane
  import npu_dsp_pkg::*;
#(
  parameter int A_W    = DSP_A_W,
  parameter int B_W    = DSP_B_W,
  parameter int P_W    = DSP_P_W,
  parameter int SIGNED = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce_i,
  input  logic           clr_i,
  input  logic           v2_i,
  input  logic           first_i,
  input  logic           publish_i,
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic [P_W-1:0] dsp_out_o,
  output logic           ovf_o
);

  localparam int PROD_W = A_W + B_W;

  logic [A_W-1:0]    a_q;
  logic [B_W-1:0]    b_q;
  logic [PROD_W-1:0] prod_d;
  logic [PROD_W-1:0] prod_q;
  logic [P_W-1:0]    acc_q;
  logic [P_W-1:0]    acc_base;
  logic [P_W-1:0]    sum;
  logic              ovf_add;
  logic              ovf_q;
  logic [P_W-1:0]    dsp_out_q;

  generate
    if (SIGNED != 0) begin : g_smul
      assign prod_d = PROD_W'($signed(a_q)) * PROD_W'($signed(b_q));
    end else begin : g_umul
      assign prod_d = PROD_W'(a_q) * PROD_W'(b_q);
    end
  endgenerate

  // NOTE: the operand and product registers are deliberately left without reset so they fold
  // into the DSP slice pipeline registers; the shared valid bits say when their contents matter.
  always_ff @(posedge clk) begin
    if (ce_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      prod_q <= prod_d;
    end
  end

  // First tap of a window overwrites the accumulator instead of adding to it.
  assign acc_base         = first_i ? '0 : acc_q;
  assign {ovf_add, sum}   = sat_add(acc_base, prod_q, SIGNED != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      dsp_out_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (ce_i && v2_i) begin
      acc_q <= sum;
      ovf_q <= ovf_q | ovf_add;
      if (publish_i) begin
        dsp_out_q <= sum;
      end
    end
  end

  assign dsp_out_o = dsp_out_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/dsp_mac_array.sv
// N_LANES pipelined multiply-accumulate lanes summing TAPS products per window.
// Owns the shared valid chain, the tap counter, the completion pulse and the busy flag.
module dsp_mac_array
  import npu_dsp_pkg::*;
#(
  parameter int N_LANES = 16,
  parameter int A_W     = DSP_A_W,
  parameter int B_W     = DSP_B_W,
  parameter int P_W     = DSP_P_W,
  parameter int TAPS    = CONV_TAPS,
  parameter int SIGNED  = 0
) (
  input logic             clk,
  input logic             rst_n,
  dsp_mac_array_if.slave  bus
);

  localparam int               CNT_W    = $clog2(TAPS + 1);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  logic             v1_q;
  logic             v2_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] tap_cnt_q;
  logic [CNT_W-1:0] tap_cnt_d;
  logic             publish;

  logic [N_LANES-1:0][P_W-1:0] lane_out;
  logic [N_LANES-1:0]          lane_ovf;

  // Every ce cycle is a tap; S3 fires when a tap reaches it and clr is not flushing.
  assign publish   = bus.dsp_ce & ~bus.dsp_clr & v2_q & (tap_cnt_q == LAST_TAP);
  assign tap_cnt_d = (tap_cnt_q == LAST_TAP) ? '0 : tap_cnt_q + 1'b1;

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      tap_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.dsp_clr) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      tap_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= publish;
      if (bus.dsp_ce) begin
        v1_q <= 1'b1;
        v2_q <= v1_q;
        if (v2_q) begin
          tap_cnt_q <= tap_cnt_d;
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
      dsp_mac_lane #(
        .A_W    (A_W),
        .B_W    (B_W),
        .P_W    (P_W),
        .SIGNED (SIGNED)
      ) u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce_i      (bus.dsp_ce),
        .clr_i     (bus.dsp_clr),
        .v2_i      (v2_q),
        .first_i   (tap_cnt_q == '0),
        .publish_i (publish),
        .a_i       (bus.dsp_a0[g]),
        .b_i       (bus.dsp_b0[g]),
        .dsp_out_o (lane_out[g]),
        .ovf_o     (lane_ovf[g])
      );
    end
  endgenerate

  assign bus.dsp_out   = lane_out;
  assign bus.ovf       = lane_ovf;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (tap_cnt_q != '0) | v1_q | v2_q;

endmodule

// File: tb/tb_dsp_mac_array.sv
// Drives an unsigned and a signed MAC array with identical stimulus and compares both against
// a window-sum reference model built from a queue of in-flight taps.
module tb_dsp_mac_array;

  localparam int     NL   = 16;
  localparam int     TAPS = 9;
  localparam longint UMAX = 64'sh1F_FFFF_FFFF;
  localparam longint SMAX = 64'sh0F_FFFF_FFFF;
  localparam longint SMIN = -SMAX - 1;

  typedef struct packed {
    logic [NL-1:0][17:0] a;
    logic [NL-1:0][17:0] b;
  } tap_t;

  logic                clk;
  logic                rst_n;
  logic                ce;
  logic                clr;
  logic [NL-1:0][17:0] a;
  logic [NL-1:0][17:0] b;

  dsp_mac_array_if #(.N_LANES(NL), .A_W(18), .B_W(18), .P_W(37)) bus_u ();
  dsp_mac_array_if #(.N_LANES(NL), .A_W(18), .B_W(18), .P_W(37)) bus_s ();

  assign bus_u.dsp_ce  = ce;
  assign bus_u.dsp_clr = clr;
  assign bus_u.dsp_a0  = a;
  assign bus_u.dsp_b0  = b;
  assign bus_s.dsp_ce  = ce;
  assign bus_s.dsp_clr = clr;
  assign bus_s.dsp_a0  = a;
  assign bus_s.dsp_b0  = b;

  dsp_mac_array #(.N_LANES(NL), .A_W(18), .B_W(18), .P_W(37), .TAPS(TAPS), .SIGNED(0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_u)
  );

  dsp_mac_array #(.N_LANES(NL), .A_W(18), .B_W(18), .P_W(37), .TAPS(TAPS), .SIGNED(1)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: taps in the two register stages, the open window, and held results.
  tap_t   pipe[$];
  int     wcnt;
  bit     exp_valid;
  longint acc_m [2][NL];
  longint out_m [2][NL];
  bit     ovf_m [2][NL];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sval(input logic [17:0] x);
    return x[17] ? longint'(x) - 64'sd262144 : longint'(x);
  endfunction

  task automatic model_reset();
    pipe.delete();
    wcnt      = 0;
    exp_valid = 1'b0;
    for (int m = 0; m < 2; m++)
      for (int l = 0; l < NL; l++) begin
        acc_m[m][l] = 0;
        out_m[m][l] = 0;
        ovf_m[m][l] = 1'b0;
      end
  endtask

  task automatic apply_tap(input tap_t t);
    longint pu, ps, s;
    for (int l = 0; l < NL; l++) begin
      pu = longint'(t.a[l]) * longint'(t.b[l]);
      ps = sval(t.a[l]) * sval(t.b[l]);
      if (wcnt == 0) begin
        acc_m[0][l] = pu;
        acc_m[1][l] = ps;
      end else begin
        s = acc_m[0][l] + pu;
        if (s > UMAX) begin s = UMAX; ovf_m[0][l] = 1'b1; end
        acc_m[0][l] = s;
        s = acc_m[1][l] + ps;
        if (s > SMAX) begin s = SMAX; ovf_m[1][l] = 1'b1; end
        else if (s < SMIN) begin s = SMIN; ovf_m[1][l] = 1'b1; end
        acc_m[1][l] = s;
      end
    end
    wcnt++;
    if (wcnt == TAPS) begin
      wcnt      = 0;
      exp_valid = 1'b1;
      for (int m = 0; m < 2; m++)
        for (int l = 0; l < NL; l++) out_m[m][l] = acc_m[m][l];
    end
  endtask

  task automatic model_step();
    tap_t t;
    exp_valid = 1'b0;
    if (clr) begin
      pipe.delete();
      wcnt = 0;
      for (int m = 0; m < 2; m++)
        for (int l = 0; l < NL; l++) begin
          acc_m[m][l] = 0;
          ovf_m[m][l] = 1'b0;
        end
    end else if (ce) begin
      t.a = a;
      t.b = b;
      pipe.push_back(t);
      if (pipe.size() > 2) apply_tap(pipe.pop_front());
    end
  endtask

  task automatic compare_all();
    logic [NL-1:0] ev0, ev1;
    logic          ebusy;
    longint        e;
    ebusy = (wcnt != 0) || (pipe.size() != 0);
    for (int l = 0; l < NL; l++) begin
      ev0[l] = ovf_m[0][l];
      ev1[l] = ovf_m[1][l];
    end
    check("out_valid_u", bus_u.out_valid, exp_valid);
    check("out_valid_s", bus_s.out_valid, exp_valid);
    check("busy_u", bus_u.busy, ebusy);
    check("busy_s", bus_s.busy, ebusy);
    check("ovf_u", bus_u.ovf, ev0);
    check("ovf_s", bus_s.ovf, ev1);
    for (int l = 0; l < NL; l++) begin
      e = out_m[0][l];
      check($sformatf("dsp_out_u[%0d]", l), {27'b0, bus_u.dsp_out[l]}, e & UMAX);
      e = out_m[1][l];
      check($sformatf("dsp_out_s[%0d]", l), {27'b0, bus_s.dsp_out[l]}, e & UMAX);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit ce_v, input bit clr_v);
    ce  = ce_v;
    clr = clr_v;
    tick();
  endtask

  task automatic set_all(input logic [17:0] av, input logic [17:0] bv);
    for (int l = 0; l < NL; l++) begin
      a[l] = av;
      b[l] = bv;
    end
  endtask

  task automatic rand_ops();
    for (int l = 0; l < NL; l++) begin
      case ($urandom_range(0, 3))
        0:       begin a[l] = 18'h3FFFF;          b[l] = 18'h3FFFF; end
        1:       begin a[l] = 18'($urandom_range(0, 15)); b[l] = 18'($urandom_range(0, 15)); end
        default: begin a[l] = 18'($urandom());    b[l] = 18'($urandom()); end
      endcase
    end
  endtask

  task automatic lane_ramp();
    for (int l = 0; l < NL; l++) begin
      a[l] = 18'(l + 1);
      b[l] = 18'd2;
    end
  endtask

  task automatic drain_and_idle();
    repeat (3) begin rand_ops(); drive(1'b1, 1'b0); end
    drive(1'b0, 1'b0);
  endtask

  initial begin
    longint e;
    rst_n = 1'b0;
    ce    = 1'b0;
    clr   = 1'b0;
    set_all(18'd0, 18'd0);
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // T1: lane i accumulates 9 x (i+1)*2.
    lane_ramp();
    repeat (TAPS) drive(1'b1, 1'b0);
    drain_and_idle();
    check("T1_lane0", bus_u.dsp_out[0], 37'd18);
    check("T1_lane15", bus_u.dsp_out[15], 37'd288);
    drive(1'b0, 1'b1);

    // T2: back-to-back windows.
    set_all(18'd1, 18'd1);
    repeat (TAPS) drive(1'b1, 1'b0);
    set_all(18'd3, 18'd5);
    repeat (TAPS) drive(1'b1, 1'b0);
    drain_and_idle();
    check("T2_lane0", bus_u.dsp_out[0], 37'd135);
    drive(1'b0, 1'b1);

    // T3: four-cycle stall after tap 5; operands during the stall are ignored.
    lane_ramp();
    repeat (5) drive(1'b1, 1'b0);
    repeat (4) begin rand_ops(); drive(1'b0, 1'b0); end
    lane_ramp();
    repeat (4) drive(1'b1, 1'b0);
    drain_and_idle();
    check("T3_lane7", bus_u.dsp_out[7], 37'd144);
    drive(1'b0, 1'b1);

    // T4: full-scale operands saturate every unsigned lane.
    set_all(18'h3FFFF, 18'h3FFFF);
    repeat (TAPS) drive(1'b1, 1'b0);
    drain_and_idle();
    check("T4_sat", {27'b0, bus_u.dsp_out[3]}, UMAX);
    check("T4_ovf", bus_u.ovf, 16'hFFFF);
    drive(1'b0, 1'b1);
    check("T4_ovf_clr", bus_u.ovf, 16'h0000);
    check("T4_out_kept", {27'b0, bus_u.dsp_out[3]}, UMAX);

    // T5: signed -3 * 7 over 9 taps.
    set_all(18'h3FFFD, 18'd7);
    repeat (TAPS) drive(1'b1, 1'b0);
    drain_and_idle();
    e = -189;
    check("T5_signed", {27'b0, bus_s.dsp_out[0]}, e & UMAX);
    check("T5_ovf", bus_s.ovf, 16'h0000);
    drive(1'b0, 1'b1);

    // T6: clr together with ce at tap 4 aborts the window.
    repeat (3) begin rand_ops(); drive(1'b1, 1'b0); end
    rand_ops();
    drive(1'b1, 1'b1);
    set_all(18'd1, 18'd1);
    repeat (TAPS) drive(1'b1, 1'b0);
    drain_and_idle();
    check("T6_lane0", bus_u.dsp_out[0], 37'd9);

    // Asynchronous reset in the middle of a window.
    repeat (5) begin rand_ops(); drive(1'b1, 1'b0); end
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    ce  = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Randomized traffic with stalls and occasional flushes.
    for (int c = 0; c < 400; c++) begin
      rand_ops();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end
    drain_and_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
